// File: rtl/cache_pkg.sv
// Purpose: shared types and constants for the two-way write-through read cache.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, default geometry, and the bit positions used to
// split a byte address into set index and tag.
package cache_pkg;

    localparam int WAYS    = 2;
    localparam int SETS    = 64;
    localparam int INDEX_W = 6;
    localparam int TAG_W   = 10;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;

    // Bits [1:0] are the byte offset within a word and are ignored.
    localparam int INDEX_LSB = 2;
    // The tag always starts at bit 8, independent of the set count.
    localparam int TAG_LSB   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WRITE   = 2'd2
    } state_t;

endpackage

// File: rtl/cache_controller_if.sv
// Purpose: bundles the MEM-stage request side and the SRAM-controller side of the cache.
// Latency: n/a (wires only).
// Backpressure: ready (toward the pipeline) and sram_ready (from the SRAM controller).
//
// Modports:
//   slave  - the cache controller: takes requests and sram responses,
//            drives read_data/ready and the sram request signals.
//   master - the surrounding environment (pipeline + SRAM controller model).
interface cache_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data;
    logic        sram_ready;

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_read_data, sram_ready,
        output read_data, ready, sram_rd_en, sram_wr_en, sram_address, sram_write_data
    );

    modport master (
        output rd_en, wr_en, address, write_data, sram_read_data, sram_ready,
        input  read_data, ready, sram_rd_en, sram_wr_en, sram_address, sram_write_data
    );

endinterface

// File: rtl/cache_way_array.sv
// Purpose: valid/tag/data storage for two ways plus per-set LRU bit, with hit and victim lookup.
// Latency: lookup is combinational; fill/update/invalidate take effect on the next rising edge.
// Backpressure: none; the caller decides when to write.
//
// Ports:
//   clk, inv_all          - clock; synchronous clear of all valid and LRU bits (has priority)
//   index, tag            - lookup key for the current request
//   hit, hit_way, hit_data- hit flag, which way hit (way 0 wins), its word (0 if no hit)
//   victim_way            - first invalid way, else the LRU way
//   fill_en, fill_data    - allocate tag/data into victim_way, mark valid
//   touch_en              - on a hit, make the other way least recent
//   upd_en, upd_data      - on a hit, overwrite the hit way's word
module cache_way_array
    import cache_pkg::*;
#(
    parameter int SETS_P  = 64,
    parameter int TAG_W_P = 10,
    parameter int IDX_W_P = $clog2(SETS_P)
) (
    input  logic               clk,
    input  logic               inv_all,
    input  logic [IDX_W_P-1:0] index,
    input  logic [TAG_W_P-1:0] tag,
    output logic               hit,
    output logic               hit_way,
    output logic [DATA_W-1:0]  hit_data,
    output logic               victim_way,
    input  logic               fill_en,
    input  logic [DATA_W-1:0]  fill_data,
    input  logic               touch_en,
    input  logic               upd_en,
    input  logic [DATA_W-1:0]  upd_data
);

    logic [SETS_P-1:0]  valid [WAYS];
    logic [SETS_P-1:0]  lru;       // 0: way 0 is least recently used
    logic [TAG_W_P-1:0] tag_mem  [WAYS][SETS_P];
    logic [DATA_W-1:0]  data_mem [WAYS][SETS_P];

    logic [WAYS-1:0]    way_hit;

    always_comb begin
        way_hit = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = valid[w][index] && (tag_mem[w][index] == tag);
        end
    end

    assign hit      = |way_hit;
    // Way 0 is checked first; a tag is never resident in both ways.
    assign hit_way  = ~way_hit[0];
    assign hit_data = way_hit[0] ? data_mem[0][index] :
                      way_hit[1] ? data_mem[1][index] : '0;

    assign victim_way = !valid[0][index] ? 1'b0 :
                        !valid[1][index] ? 1'b1 : lru[index];

    // Valid and LRU bits are the only state that needs clearing.
    always_ff @(posedge clk) begin
        if (inv_all) begin
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
            end
            lru <= '0;
        end else if (fill_en) begin
            valid[victim_way][index] <= 1'b1;
            lru[index]               <= ~victim_way;
        end else if (touch_en && hit) begin
            lru[index] <= ~hit_way;
        end
    end

    // Tag/data contents are meaningless while valid is clear, so no reset here.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[victim_way][index]  <= tag;
            data_mem[victim_way][index] <= fill_data;
        end else if (upd_en && hit) begin
            data_mem[hit_way][index] <= upd_data;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Purpose: two-way set-associative write-through read cache between the MEM stage and SRAM controller.
// Latency: read hit completes in the request cycle; miss/write take 1 + L cycles (L = SRAM latency).
// Backpressure: ready=0 freezes the pipeline until sram_ready pulses; sram_ready in IDLE is ignored.
//
// Ports:
//   clk, rst  - clock; synchronous active-high reset (clears valid/LRU, abandons any transaction)
//   bus       - cache_controller_if.slave: rd_en/wr_en/address/write_data/read_data/ready on the
//               pipeline side, sram_* request/response signals on the SRAM side
module cache_controller #(
    parameter int SETS  = 64,
    parameter int TAG_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus
);

    import cache_pkg::*;

    localparam int SET_BITS = $clog2(SETS);

    state_t state_q, state_d;

    logic [SET_BITS-1:0] index;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic                hit_way;
    logic [31:0]         hit_data;
    logic                victim_way;
    logic                fill_en;
    logic                touch_en;
    logic                upd_en;

    assign index = bus.address[INDEX_LSB +: SET_BITS];
    assign tag   = bus.address[TAG_LSB +: TAG_W];

    // Address translation is the SRAM controller's job.
    assign bus.sram_address    = bus.address;
    assign bus.sram_write_data = bus.write_data;

    cache_way_array #(
        .SETS_P  (SETS),
        .TAG_W_P (TAG_W)
    ) u_ways (
        .clk        (clk),
        .inv_all    (rst),
        .index      (index),
        .tag        (tag),
        .hit        (hit),
        .hit_way    (hit_way),
        .hit_data   (hit_data),
        .victim_way (victim_way),
        .fill_en    (fill_en),
        .fill_data  (bus.sram_read_data),
        .touch_en   (touch_en),
        .upd_en     (upd_en),
        .upd_data   (bus.write_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.ready      = 1'b1;
        bus.read_data  = '0;
        bus.sram_rd_en = 1'b0;
        bus.sram_wr_en = 1'b0;
        fill_en        = 1'b0;
        touch_en       = 1'b0;
        upd_en         = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A write wins over a simultaneous read.
                if (bus.wr_en) begin
                    bus.ready = 1'b0;
                    state_d   = WRITE;
                end else if (bus.rd_en) begin
                    if (hit) begin
                        bus.read_data = hit_data;
                        touch_en      = 1'b1;
                    end else begin
                        bus.ready = 1'b0;
                        state_d   = RD_MISS;
                    end
                end
            end

            RD_MISS: begin
                bus.sram_rd_en = 1'b1;
                if (bus.sram_ready) begin
                    bus.read_data = bus.sram_read_data;
                    fill_en       = 1'b1;
                    state_d       = IDLE;
                end else begin
                    bus.ready = 1'b0;
                end
            end

            WRITE: begin
                bus.sram_wr_en = 1'b1;
                if (bus.sram_ready) begin
                    // Write-through, no-write-allocate: only a resident word is refreshed.
                    touch_en = 1'b1;
                    upd_en   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    bus.ready = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Purpose: directed, table-driven check of the cache controller against hand-computed results.
// Latency: the bench plays the SRAM controller with a per-transaction latency.
// Backpressure: every wait is a fixed number of cycles chosen by the bench.
module tb_cache_controller;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_controller_if bus ();

    cache_controller #(
        .SETS  (64),
        .TAG_W (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total  = 0;
    int n_passed = 0;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;        // SRAM wait cycles before the sram_ready pulse
        logic [31:0] sram_data;
        logic        spurious;   // pulse sram_ready during an IDLE hit
        logic        exp_hit;
        logic [31:0] exp_data;
    } xact_t;

    function automatic xact_t mk(input string name, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int lat, input logic [31:0] sram_data,
                                 input logic spurious, input logic exp_hit,
                                 input logic [31:0] exp_data);
        xact_t x;
        x.name      = name;
        x.rd        = rd;
        x.wr        = wr;
        x.addr      = addr;
        x.wdata     = wdata;
        x.lat       = lat;
        x.sram_data = sram_data;
        x.spurious  = spurious;
        x.exp_hit   = exp_hit;
        x.exp_data  = exp_data;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_xact(input xact_t x);
        int   stall;
        logic is_wr;
        is_wr              = x.wr;
        stall              = 0;
        bus.rd_en          = x.rd;
        bus.wr_en          = x.wr;
        bus.address        = x.addr;
        bus.write_data     = x.wdata;
        bus.sram_ready     = x.spurious;
        bus.sram_read_data = 32'hBAD0_BAD0;
        @(negedge clk);
        check({x.name, " sram_address"}, bus.sram_address, x.addr);
        check({x.name, " sram_write_data"}, bus.sram_write_data, x.wdata);
        check({x.name, " c0 sram_rd_en"}, 32'(bus.sram_rd_en), 32'd0);
        check({x.name, " c0 sram_wr_en"}, 32'(bus.sram_wr_en), 32'd0);
        if (x.exp_hit) begin
            check({x.name, " hit ready"}, 32'(bus.ready), 32'd1);
            check({x.name, " hit read_data"}, bus.read_data, x.exp_data);
        end else begin
            if (bus.ready !== 1'b1) stall++;
            for (int i = 0; i < x.lat; i++) begin
                @(posedge clk); #1;
                bus.sram_ready = 1'b0;
                @(negedge clk);
                if (bus.ready !== 1'b1) stall++;
                check({x.name, " wait sram_rd_en"}, 32'(bus.sram_rd_en), 32'(!is_wr));
                check({x.name, " wait sram_wr_en"}, 32'(bus.sram_wr_en), 32'(is_wr));
            end
            @(posedge clk); #1;
            bus.sram_ready     = 1'b1;
            bus.sram_read_data = x.sram_data;
            @(negedge clk);
            check({x.name, " done ready"}, 32'(bus.ready), 32'd1);
            check({x.name, " done sram_rd_en"}, 32'(bus.sram_rd_en), 32'(!is_wr));
            check({x.name, " done sram_wr_en"}, 32'(bus.sram_wr_en), 32'(is_wr));
            if (!is_wr) check({x.name, " miss read_data"}, bus.read_data, x.exp_data);
            check({x.name, " stall cycles"}, 32'(stall), 32'(x.lat + 1));
        end
        @(posedge clk); #1;
        bus.sram_ready = 1'b0;
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
    endtask

    xact_t vec [16];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec[0]  = mk("rd400 miss",   1, 0, 32'h0000_0400, 32'h0, 5, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
        vec[1]  = mk("rd400 hit",    1, 0, 32'h0000_0400, 32'h0, 0, 32'h0,         1, 1, 32'hDEAD_BEEF);
        vec[2]  = mk("rd500 fill",   1, 0, 32'h0000_0500, 32'h0, 2, 32'h5555_0500, 0, 0, 32'h5555_0500);
        vec[3]  = mk("rd600 evict",  1, 0, 32'h0000_0600, 32'h0, 1, 32'h6666_0600, 0, 0, 32'h6666_0600);
        vec[4]  = mk("rd500 rehit",  1, 0, 32'h0000_0500, 32'h0, 0, 32'h0,         0, 1, 32'h5555_0500);
        vec[5]  = mk("rd400 remiss", 1, 0, 32'h0000_0400, 32'h0, 3, 32'h4444_0400, 0, 0, 32'h4444_0400);
        vec[6]  = mk("rd404 fill",   1, 0, 32'h0000_0404, 32'h0, 2, 32'h1111_0404, 0, 0, 32'h1111_0404);
        vec[7]  = mk("wr404",        0, 1, 32'h0000_0404, 32'h0000_1234, 3, 32'h0, 0, 0, 32'h0);
        vec[8]  = mk("rd404 upd",    1, 0, 32'h0000_0404, 32'h0, 0, 32'h0,         0, 1, 32'h0000_1234);
        vec[9]  = mk("wr800 nalloc", 0, 1, 32'h0000_0800, 32'h0000_ABCD, 2, 32'h0, 0, 0, 32'h0);
        vec[10] = mk("rd800 miss",   1, 0, 32'h0000_0800, 32'h0, 1, 32'h8888_0800, 0, 0, 32'h8888_0800);
        vec[11] = mk("rd400 lruhit", 1, 0, 32'h0000_0400, 32'h0, 0, 32'h0,         0, 1, 32'h4444_0400);
        vec[12] = mk("rd500 evict8", 1, 0, 32'h0000_0500, 32'h0, 1, 32'h5555_0501, 0, 0, 32'h5555_0501);
        vec[13] = mk("rdwr404",      1, 1, 32'h0000_0404, 32'h0000_BEEF, 2, 32'h0, 0, 0, 32'h0);
        vec[14] = mk("rd404 rw",     1, 0, 32'h0000_0404, 32'h0, 0, 32'h0,         0, 1, 32'h0000_BEEF);
        vec[15] = mk("rd600 lat0",   1, 0, 32'h0000_0600, 32'h0, 0, 32'h6666_0601, 0, 0, 32'h6666_0601);

        rst                = 1'b1;
        bus.rd_en          = 1'b0;
        bus.wr_en          = 1'b0;
        bus.address        = 32'h0;
        bus.write_data     = 32'h0;
        bus.sram_read_data = 32'h0;
        bus.sram_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset sram_rd_en", 32'(bus.sram_rd_en), 32'd0);
        check("reset sram_wr_en", 32'(bus.sram_wr_en), 32'd0);
        check("reset read_data", bus.read_data, 32'h0);

        // A stray sram_ready with no request must not start anything.
        @(posedge clk); #1;
        bus.sram_ready = 1'b1;
        @(negedge clk);
        check("idle stray ready", 32'(bus.ready), 32'd1);
        @(posedge clk); #1;
        bus.sram_ready = 1'b0;
        @(negedge clk);
        check("idle stray sram_rd_en", 32'(bus.sram_rd_en), 32'd0);
        check("idle stray sram_wr_en", 32'(bus.sram_wr_en), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_xact(vec[i]);
        end

        // Reset in the middle of a read miss abandons the fill.
        bus.rd_en   = 1'b1;
        bus.address = 32'h0000_0C08;
        @(negedge clk);
        check("rstmiss c0 ready", 32'(bus.ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmiss sram_rd_en before", 32'(bus.sram_rd_en), 32'd1);
        @(posedge clk); #1;
        rst       = 1'b1;
        bus.rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmiss sram_rd_en after", 32'(bus.sram_rd_en), 32'd0);
        check("rstmiss sram_wr_en after", 32'(bus.sram_wr_en), 32'd0);
        check("rstmiss ready after", 32'(bus.ready), 32'd1);
        @(posedge clk); #1;
        run_xact(mk("rdC08 postrst", 1, 0, 32'h0000_0C08, 32'h0, 2, 32'hC0C0_0C08, 0, 0, 32'hC0C0_0C08));
        run_xact(mk("rd404 postrst", 1, 0, 32'h0000_0404, 32'h0, 1, 32'h4040_4040, 0, 0, 32'h4040_4040));
        run_xact(mk("rdC08 rehit",   1, 0, 32'h0000_0C08, 32'h0, 0, 32'h0,         0, 1, 32'hC0C0_0C08));

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
